// File: rtl/bcd_stopwatch_ctrl_if.sv
// Link between the stopwatch controller and its two-digit BCD counter.
// The controller side (master) drives enable/clear; the counter side (slave) returns value and carry.
interface bcd_stopwatch_ctrl_if;
  logic [7:0] cnt_q;
  logic       cnt_co;
  logic       cnt_ce;
  logic       cnt_clr;

  modport master (input cnt_q, input cnt_co, output cnt_ce, output cnt_clr);
  modport slave  (output cnt_q, output cnt_co, input cnt_ce, input cnt_clr);
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller with prescaler and BCD stop limit for an external 00..99 BCD counter.
// Optional lap-hold display is built only when LAP_EN is defined.
module bcd_stopwatch_ctrl #(
  parameter int DIV = 50,
  parameter int PW  = 16
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 ss,
  input  logic                 clr_req,
  input  logic                 lap,
  input  logic [7:0]           lim,
  bcd_stopwatch_ctrl_if.master cnt,
  output logic [7:0]           disp,
  output logic                 running,
  output logic                 done,
  output logic                 ovf,
  output logic                 lim_err,
  output logic [1:0]           state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  function automatic logic bcd_digit_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    lim_eff;
  logic          stop_hit;
  logic          tick;
  logic          ce;

  // An invalid limit degrades to free-run rather than stopping somewhere unreachable.
  always_comb begin
    lim_err  = bcd_digit_bad(lim[7:4]) | bcd_digit_bad(lim[3:0]);
    lim_eff  = lim_err ? 8'h00 : lim;
    stop_hit = (lim_eff != 8'h00) && (cnt.cnt_q == lim_eff);
    tick     = (state_q == RUN) && (pre_q == PRE_LAST) && !clr_req;
    ce       = tick && !stop_hit;
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
    end
  end

  // Prescaler freezes on the cycle that pauses, so a resume continues the same count period.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ovf_d   = ovf_q | (cnt.cnt_co & ce);
    if (clr_req) begin
      state_d = IDLE;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (tick)
            pre_d = '0;
          else if (!stop_hit && !ss)
            pre_d = pre_q + 1'b1;
          if (stop_hit)
            state_d = DONE;
          else if (ss)
            state_d = PAUSE;
        end
        PAUSE: begin
          if (ss)
            state_d = RUN;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LAP_EN
  logic       lap_act_q, lap_act_d;
  logic [7:0] lap_reg_q, lap_reg_d;
  logic       lap_ok;

  always_comb begin
    lap_ok    = lap && !clr_req && ((state_q == RUN) || (state_q == PAUSE));
    lap_act_d = clr_req ? 1'b0 : (lap_ok ? !lap_act_q : lap_act_q);
    lap_reg_d = (lap_ok && !lap_act_q) ? cnt.cnt_q : lap_reg_q;
  end

  always_ff @(posedge clk) begin
    if (!R)
      lap_act_q <= 1'b0;
    else
      lap_act_q <= lap_act_d;
    lap_reg_q <= lap_reg_d;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
`endif

  always_comb begin
    running = (state_q == RUN);
    done    = (state_q == DONE);
    state   = state_q;
    ovf     = ovf_q;
`ifdef LAP_EN
    disp    = lap_act_q ? lap_reg_q : cnt.cnt_q;
`else
    disp    = cnt.cnt_q;
`endif
  end

  assign cnt.cnt_ce  = ce;
  assign cnt.cnt_clr = !R | clr_req;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl with DIV=4 and a behavioural BCD counter on the link interface.
// Build with LAP_EN defined to exercise the lap-hold display expectations.
module tb_bcd_stopwatch_ctrl;
  logic       clk;
  logic       R;
  logic       ss;
  logic       clr_req;
  logic       lap;
  logic [7:0] lim;
  logic [7:0] disp;
  logic       running;
  logic       done;
  logic       ovf;
  logic       lim_err;
  logic [1:0] state;

  logic [7:0] cq;
  logic       load_en;
  logic [7:0] load_val;

  int         n_cmp;
  int         n_bad;
  int         sb_cyc[$];
  logic [7:0] sb_val[$];

  bcd_stopwatch_ctrl_if bus ();

  bcd_stopwatch_ctrl #(.DIV(4), .PW(16)) dut (
    .clk     (clk),
    .R       (R),
    .ss      (ss),
    .clr_req (clr_req),
    .lap     (lap),
    .lim     (lim),
    .cnt     (bus),
    .disp    (disp),
    .running (running),
    .done    (done),
    .ovf     (ovf),
    .lim_err (lim_err),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    if (v[3:0] >= 4'd9) begin
      t = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      return {t, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD counter standing in for the real display counter.
  always_ff @(posedge clk) begin
    if (bus.cnt_clr)
      cq <= 8'h00;
    else if (load_en)
      cq <= load_val;
    else if (bus.cnt_ce)
      cq <= bcd_inc(cq);
  end
  assign bus.cnt_q  = cq;
  assign bus.cnt_co = bus.cnt_ce & (cq == 8'h99);

  task automatic advance();
    @(posedge clk);
    #1;
    ss      = 1'b0;
    clr_req = 1'b0;
    lap     = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cnt_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cnt_clr: got %b want 1", bus.cnt_clr);
    end
    advance();
    advance();
    R = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || running !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || bus.cnt_ce !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d run=%b done=%b ovf=%b ce=%b want 0,0,0,0,0",
               state, running, done, ovf, bus.cnt_ce);
    end
    n_cmp++;
    if (cq !== 8'h00 || disp !== 8'h00 || lim_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_value: cnt=%h disp=%h lim_err=%b want 00,00,0", cq, disp, lim_err);
    end
    advance();
  endtask

  task automatic test_run_ticks();
    int         exp_c;
    logic [7:0] exp_v;
    logic       seen;
    logic       popped;
    lim = 8'h00;
    clr_req = 1'b1;
    advance();
    sb_cyc.delete();
    sb_val.delete();
    for (int k = 1; k <= 3; k++) begin
      sb_cyc.push_back(4 * k);
      sb_val.push_back(8'(k));
    end
    ss = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      seen   = bus.cnt_ce;
      popped = 1'b0;
      exp_v  = 8'h00;
      if (c >= 1) begin
        n_cmp++;
        if (running !== 1'b1 || state !== 2'd1) begin
          n_bad++;
          $display("FAIL run_state c=%0d: running=%b state=%0d want 1,1", c, running, state);
        end
      end
      if (seen) begin
        n_cmp++;
        if (sb_cyc.size() == 0) begin
          n_bad++;
          $display("FAIL run_tick: unexpected cnt_ce at cycle %0d, none expected", c);
        end else begin
          exp_c  = sb_cyc.pop_front();
          exp_v  = sb_val.pop_front();
          popped = 1'b1;
          if (c !== exp_c) begin
            n_bad++;
            $display("FAIL run_tick: cnt_ce at cycle %0d want cycle %0d", c, exp_c);
          end
        end
      end
      advance();
      if (popped) begin
        n_cmp++;
        if (cq !== exp_v) begin
          n_bad++;
          $display("FAIL run_value: cnt_q=%h want %h", cq, exp_v);
        end
      end
    end
    n_cmp++;
    if (sb_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL run_missing: %0d ticks outstanding want 0", sb_cyc.size());
    end
  endtask

  task automatic test_pause();
    int exp_c;
    clr_req = 1'b1;
    advance();
    sb_cyc.delete();
    sb_val.delete();
    sb_cyc.push_back(16);
    sb_val.push_back(8'h01);
    for (int c = 0; c < 18; c++) begin
      if (c == 0 || c == 3 || c == 14)
        ss = 1'b1;
      @(negedge clk);
      if (c >= 4 && c <= 14) begin
        n_cmp++;
        if (state !== 2'd2 || bus.cnt_ce !== 1'b0) begin
          n_bad++;
          $display("FAIL pause_hold c=%0d: state=%0d ce=%b want 2,0", c, state, bus.cnt_ce);
        end
      end
      if (bus.cnt_ce) begin
        n_cmp++;
        if (sb_cyc.size() == 0) begin
          n_bad++;
          $display("FAIL pause_tick: unexpected cnt_ce at cycle %0d, none expected", c);
        end else begin
          exp_c = sb_cyc.pop_front();
          void'(sb_val.pop_front());
          if (c !== exp_c) begin
            n_bad++;
            $display("FAIL pause_tick: cnt_ce at cycle %0d want cycle %0d", c, exp_c);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (sb_cyc.size() != 0 || cq !== 8'h01) begin
      n_bad++;
      $display("FAIL pause_resume: outstanding=%0d cnt=%h want 0,01", sb_cyc.size(), cq);
    end
  endtask

  task automatic test_limit();
    int         exp_c;
    logic [7:0] exp_v;
    int         q12_c;
    int         done_c;
    clr_req = 1'b1;
    advance();
    lim = 8'h12;
    q12_c  = -1;
    done_c = -1;
    sb_cyc.delete();
    sb_val.delete();
    for (int k = 1; k <= 12; k++) begin
      sb_cyc.push_back(4 * k);
      sb_val.push_back(8'((k / 10) * 16 + (k % 10)));
    end
    for (int c = 0; c < 60; c++) begin
      if (c == 0 || c == 52 || c == 55 || c == 58)
        ss = 1'b1;
      @(negedge clk);
      if (cq == 8'h12 && q12_c < 0)
        q12_c = c;
      if (done === 1'b1 && done_c < 0)
        done_c = c;
      if (bus.cnt_ce) begin
        n_cmp++;
        if (cq === lim) begin
          n_bad++;
          $display("FAIL limit_ce_at_lim: cnt_ce=1 with cnt_q=%h want 0", cq);
        end
        if (sb_cyc.size() == 0) begin
          n_bad++;
          $display("FAIL limit_tick: unexpected cnt_ce at cycle %0d, none expected", c);
        end else begin
          exp_c = sb_cyc.pop_front();
          exp_v = sb_val.pop_front();
          if (c !== exp_c || bcd_inc(cq) !== exp_v) begin
            n_bad++;
            $display("FAIL limit_tick: cycle %0d next=%h want cycle %0d next=%h",
                     c, bcd_inc(cq), exp_c, exp_v);
          end
        end
      end
      if (c >= 50) begin
        n_cmp++;
        if (done !== 1'b1 || state !== 2'd3 || running !== 1'b0) begin
          n_bad++;
          $display("FAIL limit_done c=%0d: done=%b state=%0d run=%b want 1,3,0", c, done, state, running);
        end
      end
      advance();
    end
    n_cmp++;
    if (q12_c !== 49 || done_c !== 50) begin
      n_bad++;
      $display("FAIL limit_timing: cnt==12 at %0d done at %0d want 49,50", q12_c, done_c);
    end
    n_cmp++;
    if (cq !== 8'h12 || sb_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL limit_final: cnt=%h outstanding=%0d want 12,0", cq, sb_cyc.size());
    end
    lim = 8'h00;
    clr_req = 1'b1;
    advance();
  endtask

  task automatic test_ovf();
    clr_req = 1'b1;
    advance();
    load_en  = 1'b1;
    load_val = 8'h98;
    advance();
    for (int c = 0; c < 11; c++) begin
      if (c == 0)
        ss = 1'b1;
      @(negedge clk);
      if (c == 4 || c == 8) begin
        n_cmp++;
        if (bus.cnt_ce !== 1'b1 || bus.cnt_co !== (c == 8)) begin
          n_bad++;
          $display("FAIL ovf_tick c=%0d: ce=%b co=%b want 1,%0d", c, bus.cnt_ce, bus.cnt_co, (c == 8));
        end
      end
      if (c == 8 || c == 9) begin
        n_cmp++;
        if (ovf !== (c == 9)) begin
          n_bad++;
          $display("FAIL ovf_flag c=%0d: ovf=%b want %0d", c, ovf, (c == 9));
        end
      end
      advance();
    end
    n_cmp++;
    if (cq !== 8'h00 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_wrap: cnt=%h ovf=%b want 00,1", cq, ovf);
    end
    clr_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cnt_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_clr_pulse: cnt_clr=%b want 1", bus.cnt_clr);
    end
    advance();
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0 || cq !== 8'h00 || state !== 2'd0) begin
      n_bad++;
      $display("FAIL ovf_cleared: ovf=%b cnt=%h state=%0d want 0,00,0", ovf, cq, state);
    end
    advance();
  endtask

  task automatic test_ss_clr_and_lim_err();
    logic [7:0] pat[5];
    logic       want[5];
    pat  = '{8'hA5, 8'h5A, 8'h99, 8'h90, 8'h09};
    want = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clr_req = 1'b1;
    advance();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)
        ss = 1'b1;
      advance();
    end
    ss      = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cnt_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL ssclr_clr: cnt_clr=%b want 1", bus.cnt_clr);
    end
    advance();
    advance();
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || cq !== 8'h00) begin
      n_bad++;
      $display("FAIL ssclr_state: state=%0d cnt=%h want 0,00", state, cq);
    end
    for (int i = 0; i < 5; i++) begin
      lim = pat[i];
      #1;
      n_cmp++;
      if (lim_err !== want[i]) begin
        n_bad++;
        $display("FAIL lim_err lim=%h: got %b want %b", pat[i], lim_err, want[i]);
      end
    end
    advance();
    lim      = 8'hA5;
    load_en  = 1'b1;
    load_val = 8'hA5;
    advance();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)
        ss = 1'b1;
      @(negedge clk);
      if (c >= 1) begin
        n_cmp++;
        if (state !== 2'd1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL limerr_freerun c=%0d: state=%0d done=%b want 1,0", c, state, done);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.cnt_ce !== 1'b1) begin
          n_bad++;
          $display("FAIL limerr_tick: ce=%b want 1", bus.cnt_ce);
        end
      end
      advance();
    end
    lim = 8'h00;
    clr_req = 1'b1;
    advance();
  endtask

  task automatic test_reset_mid_run();
    clr_req = 1'b1;
    advance();
    load_en  = 1'b1;
    load_val = 8'h99;
    advance();
    for (int c = 0; c < 7; c++) begin
      if (c == 0)
        ss = 1'b1;
      if (c == 6) begin
        load_en  = 1'b1;
        load_val = 8'h37;
      end
      advance();
    end
    @(negedge clk);
    n_cmp++;
    if (cq !== 8'h37 || ovf !== 1'b1 || state !== 2'd1) begin
      n_bad++;
      $display("FAIL midrst_pre: cnt=%h ovf=%b state=%0d want 37,1,1", cq, ovf, state);
    end
    advance();
    R = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cnt_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_clr: cnt_clr=%b want 1", bus.cnt_clr);
    end
    advance();
    R = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cq !== 8'h00 || state !== 2'd0 || ovf !== 1'b0 || done !== 1'b0 || running !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_post: cnt=%h state=%0d ovf=%b done=%b run=%b want 00,0,0,0,0",
               cq, state, ovf, done, running);
    end
    advance();
  endtask

  task automatic test_disp();
    logic [7:0] exp_d;
    clr_req = 1'b1;
    advance();
    load_en  = 1'b1;
    load_val = 8'h04;
    advance();
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        ss  = 1'b1;
        lap = 1'b1;
      end
      if (c == 5 || c == 13)
        lap = 1'b1;
      @(negedge clk);
`ifdef LAP_EN
      exp_d = (c >= 6 && c <= 13) ? 8'h05 : cq;
`else
      exp_d = cq;
`endif
      n_cmp++;
      if (disp !== exp_d) begin
        n_bad++;
        $display("FAIL disp c=%0d: disp=%h want %h (cnt=%h)", c, disp, exp_d, cq);
      end
      advance();
    end
    n_cmp++;
    if (cq !== 8'h07) begin
      n_bad++;
      $display("FAIL disp_count: cnt=%h want 07", cq);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    R        = 1'b0;
    ss       = 1'b0;
    clr_req  = 1'b0;
    lap      = 1'b0;
    lim      = 8'h00;
    load_en  = 1'b0;
    load_val = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_run_ticks();
    test_pause();
    test_limit();
    test_ovf();
    test_ss_clr_and_lim_err();
    test_reset_mid_run();
    test_disp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
